// File: rtl/chacha_stream_ctrl.sv
// Stream wrapper around a ChaCha20 block core: packs 32-bit plaintext words into
// 512-bit blocks, sequences init/next requests, and serialises the XORed result.
module chacha_stream_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic [63:0]  iv_in,
    input  logic [63:0]  ctr_in,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
    output logic         core_init,
    output logic         core_next,
    output logic [255:0] core_key,
    output logic [63:0]  core_iv,
    output logic [63:0]  core_ctr,
    output logic [511:0] core_data,
    input  logic         core_ready,
    input  logic         core_valid,
    input  logic [511:0] core_dout,
    output logic         busy,
    output logic         done,
    output logic         ctr_wrap
);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t             state_q;
    // Element 0 of a [0:15] packed array occupies bits [511:480], matching word order.
    logic [0:15][31:0]  ibuf_q;
    logic [0:15][31:0]  obuf_q;
    logic [3:0]         wr_idx_q;
    logic [3:0]         rd_idx_q;
    logic [4:0]         n_words_q;
    logic               last_blk_q;
    logic               first_q;
    logic               init_q;
    logic               next_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;
    logic [255:0]       key_q;
    logic [63:0]        iv_q;
    logic [63:0]        ctr_q;

    logic               rd_at_end_d;
    logic               in_last_d;

    assign rd_at_end_d = ({1'b0, rd_idx_q} == (n_words_q - 5'd1));
    assign in_last_d   = (wr_idx_q == 4'd15) || s_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ibuf_q     <= '0;
            obuf_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            n_words_q  <= '0;
            last_blk_q <= 1'b0;
            first_q    <= 1'b0;
            init_q     <= 1'b0;
            next_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            key_q      <= '0;
            iv_q       <= '0;
            ctr_q      <= '0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q    <= key_in;
                        iv_q     <= iv_in;
                        ctr_q    <= ctr_in;
                        first_q  <= 1'b1;
                        wrap_q   <= 1'b0;
                        ibuf_q   <= '0;
                        wr_idx_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= FILL;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        ibuf_q[wr_idx_q] <= s_data;
                        if (in_last_d) begin
                            n_words_q  <= {1'b0, wr_idx_q} + 5'd1;
                            last_blk_q <= s_last;
                            state_q    <= ISSUE;
                        end else begin
                            wr_idx_q <= wr_idx_q + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        init_q  <= first_q;
                        next_q  <= !first_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        obuf_q   <= core_dout;
                        rd_idx_q <= '0;
                        ctr_q    <= ctr_q + 64'd1;
                        if (&ctr_q) begin
                            wrap_q <= 1'b1;
                        end
                        first_q  <= 1'b0;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (rd_at_end_d) begin
                            if (last_blk_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                ibuf_q   <= '0;
                                wr_idx_q <= '0;
                                state_q  <= FILL;
                            end
                        end else begin
                            rd_idx_q <= rd_idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stream handshake signals decode directly from state and index registers.
    assign s_ready   = (state_q == FILL);
    assign m_valid   = (state_q == DRAIN);
    assign m_data    = m_valid ? obuf_q[rd_idx_q] : 32'd0;
    assign m_last    = m_valid && last_blk_q && rd_at_end_d;

    assign core_init = init_q;
    assign core_next = next_q;
    assign core_key  = key_q;
    assign core_iv   = iv_q;
    assign core_ctr  = ctr_q;
    assign core_data = ibuf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ctr_wrap  = wrap_q;

endmodule
